// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I data-memory access path.
//   lsu_size_e    : access size encoding carried on i_req_size (2'b11 is illegal)
//   lsu_state_e   : load/store unit FSM states
//   AXI_RESP_OKAY : AXI response code for a successful transfer
//   lsu_base_strb : byte-lane strobe for an access of the given size at lane 0
package rv32i_pkg;

    typedef enum logic [1:0] {
        LSU_BYTE = 2'b00,
        LSU_HALF = 2'b01,
        LSU_WORD = 2'b10
    } lsu_size_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_WRESP = 3'd2,
        ST_RADDR = 3'd3,
        ST_RDATA = 3'd4,
        ST_RESP  = 3'd5
    } lsu_state_e;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    // Strobe pattern before shifting to the addressed byte lane.
    function automatic logic [3:0] lsu_base_strb(input logic [1:0] size);
        logic [3:0] strb;
        case (size)
            LSU_BYTE: strb = 4'b0001;
            LSU_HALF: strb = 4'b0011;
            LSU_WORD: strb = 4'b1111;
            default:  strb = 4'b0000;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/if_axi_lite.sv
// AXI-Lite bundle (AW, W, B, AR, R channels).
//   master modport : drives addresses, write data, BREADY/RREADY
//   slave  modport : drives ready signals, write response and read data
interface if_axi_lite #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane alignment for the load/store unit.
//   addr_lo/size/sign : low address bits, access size, load sign-extend select
//   st_data           : LSB-justified store data -> wdata/wstrb placed on the addressed lanes
//   bus_rdata         : raw bus read word -> ld_data shifted down and extended
//   misaligned        : access crosses its natural boundary or size is illegal
module lsu_align
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]        addr_lo,
    input  logic [1:0]        size,
    input  logic              sign,
    input  logic [XLEN-1:0]   st_data,
    output logic [XLEN-1:0]   wdata,
    output logic [XLEN/8-1:0] wstrb,
    input  logic [XLEN-1:0]   bus_rdata,
    output logic [XLEN-1:0]   ld_data,
    output logic              misaligned
);
    logic [4:0]      shamt_s;
    logic [XLEN-1:0] shifted_s;

    assign shamt_s   = {addr_lo, 3'b000};
    assign wdata     = st_data << shamt_s;
    assign wstrb     = lsu_base_strb(size) << addr_lo;
    assign shifted_s = bus_rdata >> shamt_s;

    assign misaligned = ((size == LSU_HALF) & addr_lo[0])
                      | ((size == LSU_WORD) & (addr_lo != 2'b00))
                      | (size == 2'b11);

    // Extend the addressed byte/half to a full register value.
    always_comb begin
        ld_data = {XLEN{1'b0}};
        case (lsu_size_e'(size))
            LSU_BYTE: ld_data = sign ? {{(XLEN-8){shifted_s[7]}}, shifted_s[7:0]}
                                     : {{(XLEN-8){1'b0}}, shifted_s[7:0]};
            LSU_HALF: ld_data = sign ? {{(XLEN-16){shifted_s[15]}}, shifted_s[15:0]}
                                     : {{(XLEN-16){1'b0}}, shifted_s[15:0]};
            LSU_WORD: ld_data = bus_rdata;
            default:  ld_data = {XLEN{1'b0}};
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: takes one request per valid/ready handshake, performs a single
// AXI-Lite read or write on m_axi, and returns the aligned/extended load result.
//   clk, rst                  : clock, synchronous active-high reset
//   i_req_* / o_req_ready     : request channel (address, store flag, size, sign, store data)
//   o_rsp_* / i_rsp_ready     : response channel (load data, error flag)
//   m_axi                     : AXI-Lite master to data memory
// Only one transaction is ever in flight; misaligned or illegal-size requests
// are answered with an error without touching the bus.
module load_store_unit
    import rv32i_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ADDRLEN = XLEN
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_req_valid,
    output logic               o_req_ready,
    input  logic [ADDRLEN-1:0] i_req_addr,
    input  logic               i_req_we,
    input  logic [1:0]         i_req_size,
    input  logic               i_req_sign,
    input  logic [XLEN-1:0]    i_req_wdata,
    output logic               o_rsp_valid,
    input  logic               i_rsp_ready,
    output logic [XLEN-1:0]    o_rsp_rdata,
    output logic               o_rsp_err,
    if_axi_lite.master         m_axi
);
    lsu_state_e          state_r;
    lsu_state_e          state_next_s;
    logic [ADDRLEN-1:0]  req_addr_r;
    logic [1:0]          req_size_r;
    logic                req_sign_r;
    logic [XLEN-1:0]     req_wdata_r;
    logic                aw_done_r;
    logic                w_done_r;
    logic [XLEN-1:0]     rsp_rdata_r;
    logic                rsp_err_r;

    logic                accept_s;
    logic                aw_hs_s;
    logic                w_hs_s;
    logic                b_hs_s;
    logic                ar_hs_s;
    logic                r_hs_s;
    logic [1:0]          align_addr_s;
    logic [1:0]          align_size_s;
    logic [XLEN-1:0]     st_wdata_s;
    logic [XLEN/8-1:0]   st_wstrb_s;
    logic [XLEN-1:0]     ld_data_s;
    logic                misaligned_s;

    assign accept_s = (state_r == ST_IDLE) & i_req_valid;

    // In IDLE the aligner looks at the incoming request so misalignment is known
    // at accept time; afterwards it works from the captured request.
    assign align_addr_s = (state_r == ST_IDLE) ? i_req_addr[1:0] : req_addr_r[1:0];
    assign align_size_s = (state_r == ST_IDLE) ? i_req_size      : req_size_r;

    lsu_align #(.XLEN(XLEN)) u_align (
        .addr_lo    (align_addr_s),
        .size       (align_size_s),
        .sign       (req_sign_r),
        .st_data    (req_wdata_r),
        .wdata      (st_wdata_s),
        .wstrb      (st_wstrb_s),
        .bus_rdata  (m_axi.rdata),
        .ld_data    (ld_data_s),
        .misaligned (misaligned_s)
    );

    // Bus side: all controls decode from registered state, so valids stay
    // stable until their own handshake.
    assign m_axi.awaddr  = {req_addr_r[ADDRLEN-1:2], 2'b00};
    assign m_axi.awprot  = 3'b000;
    assign m_axi.awvalid = (state_r == ST_WRITE) & ~aw_done_r;
    assign m_axi.wdata   = st_wdata_s;
    assign m_axi.wstrb   = st_wstrb_s;
    assign m_axi.wvalid  = (state_r == ST_WRITE) & ~w_done_r;
    assign m_axi.bready  = (state_r == ST_WRESP);
    assign m_axi.araddr  = {req_addr_r[ADDRLEN-1:2], 2'b00};
    assign m_axi.arprot  = 3'b000;
    assign m_axi.arvalid = (state_r == ST_RADDR);
    assign m_axi.rready  = (state_r == ST_RDATA);

    assign aw_hs_s = m_axi.awvalid & m_axi.awready;
    assign w_hs_s  = m_axi.wvalid  & m_axi.wready;
    assign b_hs_s  = m_axi.bvalid  & m_axi.bready;
    assign ar_hs_s = m_axi.arvalid & m_axi.arready;
    assign r_hs_s  = m_axi.rvalid  & m_axi.rready;

    assign o_req_ready = (state_r == ST_IDLE);
    assign o_rsp_valid = (state_r == ST_RESP);
    assign o_rsp_rdata = rsp_rdata_r;
    assign o_rsp_err   = rsp_err_r;

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (i_req_valid) begin
                    if (misaligned_s)  state_next_s = ST_RESP;
                    else if (i_req_we) state_next_s = ST_WRITE;
                    else               state_next_s = ST_RADDR;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                // AW and W may finish in either order or together.
                if ((aw_done_r | aw_hs_s) & (w_done_r | w_hs_s)) state_next_s = ST_WRESP;
                else                                             state_next_s = ST_WRITE;
            end
            ST_WRESP: begin
                if (b_hs_s) state_next_s = ST_RESP;
                else        state_next_s = ST_WRESP;
            end
            ST_RADDR: begin
                if (ar_hs_s) state_next_s = ST_RDATA;
                else         state_next_s = ST_RADDR;
            end
            ST_RDATA: begin
                if (r_hs_s) state_next_s = ST_RESP;
                else        state_next_s = ST_RDATA;
            end
            ST_RESP: begin
                if (i_rsp_ready) state_next_s = ST_IDLE;
                else             state_next_s = ST_RESP;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register, request capture, channel-done tracking and response data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            req_addr_r  <= {ADDRLEN{1'b0}};
            req_size_r  <= 2'b00;
            req_sign_r  <= 1'b0;
            req_wdata_r <= {XLEN{1'b0}};
            aw_done_r   <= 1'b0;
            w_done_r    <= 1'b0;
            rsp_rdata_r <= {XLEN{1'b0}};
            rsp_err_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        req_addr_r  <= i_req_addr;
                        req_size_r  <= i_req_size;
                        req_sign_r  <= i_req_sign;
                        req_wdata_r <= i_req_wdata;
                        aw_done_r   <= 1'b0;
                        w_done_r    <= 1'b0;
                        rsp_rdata_r <= {XLEN{1'b0}};
                        rsp_err_r   <= misaligned_s;
                    end
                end
                ST_WRITE: begin
                    aw_done_r <= aw_done_r | aw_hs_s;
                    w_done_r  <= w_done_r  | w_hs_s;
                end
                ST_WRESP: begin
                    if (b_hs_s) rsp_err_r <= (m_axi.bresp != AXI_RESP_OKAY);
                end
                ST_RDATA: begin
                    if (r_hs_s) begin
                        if (m_axi.rresp != AXI_RESP_OKAY) begin
                            rsp_rdata_r <= {XLEN{1'b0}};
                            rsp_err_r   <= 1'b1;
                        end else begin
                            rsp_rdata_r <= ld_data_s;
                            rsp_err_r   <= 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed requests push expected bus
// beats and responses into queues; negedge monitors pop and compare.
module tb_load_store_unit;
    import rv32i_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [31:0] i_req_addr;
    logic        i_req_we;
    logic [1:0]  i_req_size;
    logic        i_req_sign;
    logic [31:0] i_req_wdata;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;

    always #5 clk = ~clk;

    if_axi_lite #(.ADDR_W(32), .DATA_W(32)) axi ();

    load_store_unit #(.XLEN(32), .ADDRLEN(32)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_addr(i_req_addr), .i_req_we(i_req_we), .i_req_size(i_req_size),
        .i_req_sign(i_req_sign), .i_req_wdata(i_req_wdata),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
        .m_axi(axi)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- slave model ----------------
    int          aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
    logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
    logic [31:0] r_data_cfg = 32'h0;
    int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    logic        aw_got, w_got, ar_got;

    assign axi.awready = (aw_cnt >= aw_delay);
    assign axi.wready  = (w_cnt  >= w_delay);
    assign axi.arready = (ar_cnt >= ar_delay);

    always @(posedge clk) begin
        if (rst) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
            axi.bvalid <= 1'b0; axi.bresp <= 2'b00;
            axi.rvalid <= 1'b0; axi.rresp <= 2'b00; axi.rdata <= 32'h0;
        end else begin
            aw_cnt <= (axi.awvalid && !axi.awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (axi.wvalid  && !axi.wready)  ? w_cnt + 1  : 0;
            ar_cnt <= (axi.arvalid && !axi.arready) ? ar_cnt + 1 : 0;
            if (axi.awvalid && axi.awready) aw_got <= 1'b1;
            if (axi.wvalid && axi.wready)   w_got  <= 1'b1;
            if (axi.arvalid && axi.arready) ar_got <= 1'b1;
            if (axi.bvalid) begin
                if (axi.bready) begin
                    axi.bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; b_cnt <= 0;
                end
            end else if (aw_got && w_got) begin
                if (b_cnt >= b_delay) begin
                    axi.bvalid <= 1'b1; axi.bresp <= b_resp_cfg;
                end else b_cnt <= b_cnt + 1;
            end
            if (axi.rvalid) begin
                if (axi.rready) begin
                    axi.rvalid <= 1'b0; ar_got <= 1'b0; r_cnt <= 0;
                end
            end else if (ar_got) begin
                if (r_cnt >= r_delay) begin
                    axi.rvalid <= 1'b1; axi.rdata <= r_data_cfg; axi.rresp <= r_resp_cfg;
                end else r_cnt <= r_cnt + 1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [31:0] exp_aw_q[$];
    logic [31:0] exp_wdata_q[$];
    logic [3:0]  exp_wstrb_q[$];
    logic [31:0] exp_ar_q[$];
    logic [31:0] exp_rdata_q[$];
    logic        exp_err_q[$];
    int          ar_valid_cycles = 0, aw_valid_cycles = 0, b_hs_count = 0;
    logic [31:0] e32;
    logic [3:0]  e4;
    logic        e1;

    always @(negedge clk) begin
        if (!rst) begin
            if (axi.arvalid) ar_valid_cycles++;
            if (axi.awvalid) aw_valid_cycles++;
            if (axi.bvalid && axi.bready) b_hs_count++;
            if (axi.awvalid && axi.awready) begin
                if (exp_aw_q.size() == 0) check("aw_unexpected", 32'd1, 32'd0);
                else begin
                    e32 = exp_aw_q.pop_front();
                    check("awaddr", axi.awaddr, e32);
                    check("awprot", {29'd0, axi.awprot}, 32'd0);
                end
            end
            if (axi.wvalid && axi.wready) begin
                if (exp_wdata_q.size() == 0) check("w_unexpected", 32'd1, 32'd0);
                else begin
                    e32 = exp_wdata_q.pop_front();
                    e4  = exp_wstrb_q.pop_front();
                    check("wdata", axi.wdata, e32);
                    check("wstrb", {28'd0, axi.wstrb}, {28'd0, e4});
                end
            end
            if (axi.arvalid && axi.arready) begin
                if (exp_ar_q.size() == 0) check("ar_unexpected", 32'd1, 32'd0);
                else begin
                    e32 = exp_ar_q.pop_front();
                    check("araddr", axi.araddr, e32);
                end
            end
            if (o_rsp_valid && i_rsp_ready) begin
                if (exp_rdata_q.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
                else begin
                    e32 = exp_rdata_q.pop_front();
                    e1  = exp_err_q.pop_front();
                    check("rsp_rdata", o_rsp_rdata, e32);
                    check("rsp_err", {31'd0, o_rsp_err}, {31'd0, e1});
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        exp_aw_q.push_back(a); exp_wdata_q.push_back(d); exp_wstrb_q.push_back(s);
    endtask

    task automatic push_rsp(input logic [31:0] d, input logic err);
        exp_rdata_q.push_back(d); exp_err_q.push_back(err);
    endtask

    // Present a request and return at the negedge just after it was accepted.
    task automatic issue(input logic [31:0] a, input logic we, input logic [1:0] sz,
                         input logic sg, input logic [31:0] wd);
        int n = 0;
        @(negedge clk);
        i_req_valid = 1'b1; i_req_addr = a; i_req_we = we;
        i_req_size = sz; i_req_sign = sg; i_req_wdata = wd;
        while (!o_req_ready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) check("req_accept_timeout", 32'd1, 32'd0);
        @(negedge clk);
        i_req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_rdata_q.size() != 0 || !o_req_ready) && n < 200) begin
            @(negedge clk); n++;
        end
        if (n >= 200) check("rsp_timeout", 32'd1, 32'd0);
    endtask

    function automatic logic [31:0] ctl_vec();
        return {24'd0, o_req_ready, o_rsp_valid, o_rsp_err, axi.awvalid,
                axi.wvalid, axi.arvalid, axi.bready, axi.rready};
    endfunction

    // ---------------- directed tests ----------------
    initial begin
        int n;
        int base;
        rst = 1'b1; i_req_valid = 1'b0; i_req_addr = 32'h0; i_req_we = 1'b0;
        i_req_size = 2'b00; i_req_sign = 1'b0; i_req_wdata = 32'h0; i_rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_ctl", ctl_vec(), 32'h0000_0080);
        check("reset_rdata", o_rsp_rdata, 32'h0);
        rst = 1'b0;

        // SB to byte 3
        push_w(32'h100, 32'hA500_0000, 4'b1000); push_rsp(32'h0, 1'b0);
        issue(32'h103, 1'b1, 2'b00, 1'b0, 32'h0000_00A5); wait_done();

        // LH signed / unsigned from upper half
        r_data_cfg = 32'h8001_1234;
        exp_ar_q.push_back(32'h200); push_rsp(32'hFFFF_8001, 1'b0);
        issue(32'h202, 1'b0, 2'b01, 1'b1, 32'h0); wait_done();
        exp_ar_q.push_back(32'h200); push_rsp(32'h0000_8001, 1'b0);
        issue(32'h202, 1'b0, 2'b01, 1'b0, 32'h0); wait_done();

        // Misaligned LW: error on the next cycle, no read address
        base = ar_valid_cycles;
        push_rsp(32'h0, 1'b1);
        issue(32'h301, 1'b0, 2'b10, 1'b0, 32'h0);
        check("mis_rsp_next_cycle", {31'd0, o_rsp_valid}, 32'd1);
        wait_done();
        check("mis_no_arvalid", ar_valid_cycles - base, 32'd0);

        // SW: W accepted two cycles before AW, SLVERR response
        aw_delay = 3; w_delay = 1; b_resp_cfg = 2'b10; base = b_hs_count;
        push_w(32'h400, 32'h1234_5678, 4'b1111); push_rsp(32'h0, 1'b1);
        issue(32'h400, 1'b1, 2'b10, 1'b0, 32'h1234_5678); wait_done();
        check("sw_single_b", b_hs_count - base, 32'd1);
        aw_delay = 0; w_delay = 0; b_resp_cfg = 2'b00;

        // LBU with response back-pressure held for 5 cycles
        r_data_cfg = 32'h0000_C300; i_rsp_ready = 1'b0;
        exp_ar_q.push_back(32'h500); push_rsp(32'h0000_00C3, 1'b0);
        issue(32'h501, 1'b0, 2'b00, 1'b0, 32'h0);
        n = 0;
        while (!o_rsp_valid && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) check("hold_rsp_timeout", 32'd1, 32'd0);
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", {31'd0, o_rsp_valid}, 32'd1);
            check("hold_rdata", o_rsp_rdata, 32'h0000_00C3);
            check("hold_req_ready", {31'd0, o_req_ready}, 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1 i_rsp_ready = 1'b1;
        wait_done();

        // SH to upper half, LB signed from byte 3
        push_w(32'h600, 32'hBEEF_0000, 4'b1100); push_rsp(32'h0, 1'b0);
        issue(32'h602, 1'b1, 2'b01, 1'b0, 32'h0000_BEEF); wait_done();
        r_data_cfg = 32'h8012_3456;
        exp_ar_q.push_back(32'h700); push_rsp(32'hFFFF_FF80, 1'b0);
        issue(32'h703, 1'b0, 2'b00, 1'b1, 32'h0); wait_done();

        // Load bus error: data forced to zero
        r_data_cfg = 32'hDEAD_BEEF; r_resp_cfg = 2'b11;
        exp_ar_q.push_back(32'h800); push_rsp(32'h0, 1'b1);
        issue(32'h800, 1'b0, 2'b10, 1'b0, 32'h0); wait_done();
        r_resp_cfg = 2'b00;

        // Illegal size load and misaligned halfword store: no bus activity
        base = ar_valid_cycles; push_rsp(32'h0, 1'b1);
        issue(32'h900, 1'b0, 2'b11, 1'b0, 32'h0); wait_done();
        check("illegal_no_arvalid", ar_valid_cycles - base, 32'd0);
        base = aw_valid_cycles; push_rsp(32'h0, 1'b1);
        issue(32'h601, 1'b1, 2'b01, 1'b0, 32'h0000_1111); wait_done();
        check("mis_sh_no_awvalid", aw_valid_cycles - base, 32'd0);

        // Reset while waiting for B: transaction abandoned, no response
        b_delay = 6;
        push_w(32'hA00, 32'h1122_3344, 4'b1111);
        issue(32'hA00, 1'b1, 2'b10, 1'b0, 32'h1122_3344);
        n = 0;
        while (!axi.bready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) check("wresp_reach_timeout", 32'd1, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_wresp_ctl", ctl_vec(), 32'h0000_0080);
        rst = 1'b0; b_delay = 0;
        repeat (2) @(negedge clk);
        check("rst_wresp_idle", ctl_vec(), 32'h0000_0080);

        // Normal operation after the abort
        r_data_cfg = 32'hCAFE_F00D;
        exp_ar_q.push_back(32'hB00); push_rsp(32'hCAFE_F00D, 1'b0);
        issue(32'hB00, 1'b0, 2'b10, 1'b0, 32'h0); wait_done();

        repeat (3) @(negedge clk);
        check("q_aw_empty", exp_aw_q.size(), 32'd0);
        check("q_w_empty", exp_wdata_q.size(), 32'd0);
        check("q_ar_empty", exp_ar_q.size(), 32'd0);
        check("q_rsp_empty", exp_rdata_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
